// File: rtl/uart_cmd_responder.sv
// Device-side host command responder: parses 5-byte frames from the UART receiver,
// performs local register reads/writes, and streams the response frame to the transmitter.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 104166,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  RESP_SYNC      = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic [2:0] rx_error,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    S_SYNC, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RDWAIT, S_TXLOAD, S_TXWAIT
  } state_e;

  state_e        state_q;
  logic [7:0]    cmd_q, addr_q, data_q, rdata_q;
  logic          nak_q;
  logic [1:0]    resp_idx_q, resp_last_q;
  logic [TW-1:0] timer_q;
  logic          tx_send_q, reg_we_q, reg_re_q, busy_q;
  logic [7:0]    tx_data_q, reg_addr_q, reg_wdata_q, err_count_q;

  logic       rx_ok, frame_ok, timed_out;
  logic [7:0] err_inc, tx_byte;

  assign rx_ok     = rx_done && (rx_error == 3'b000);
  assign frame_ok  = (rx_data == (cmd_q ^ addr_q ^ data_q)) &&
                     (cmd_q == CMD_WRITE || cmd_q == CMD_READ);
  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES));
  assign err_inc   = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

  always_comb begin
    tx_byte = RESP_SYNC;
    case (resp_idx_q)
      2'd0:    tx_byte = RESP_SYNC;
      2'd1:    tx_byte = nak_q ? RESP_NAK : RESP_ACK;
      2'd2:    tx_byte = rdata_q;
      default: tx_byte = RESP_ACK ^ rdata_q;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      nak_q       <= 1'b0;
      resp_idx_q  <= '0;
      resp_last_q <= '0;
      timer_q     <= '0;
      tx_send_q   <= 1'b0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      tx_send_q <= 1'b0;
      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;
      case (state_q)
        S_SYNC: begin
          timer_q <= '0;
          if (rx_ok && rx_data == SYNC_BYTE) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DATA, S_CSUM: begin
          // A byte arriving on the timeout cycle wins over the timeout.
          if (rx_done) begin
            timer_q <= '0;
            if (!rx_ok || (state_q == S_CSUM && !frame_ok)) begin
              nak_q       <= 1'b1;
              resp_idx_q  <= 2'd0;
              resp_last_q <= 2'd1;
              err_count_q <= err_inc;
              state_q     <= S_TXLOAD;
            end else if (state_q == S_CMD) begin
              cmd_q   <= rx_data;
              state_q <= S_ADDR;
            end else if (state_q == S_ADDR) begin
              addr_q  <= rx_data;
              state_q <= S_DATA;
            end else if (state_q == S_DATA) begin
              data_q  <= rx_data;
              state_q <= S_CSUM;
            end else begin
              reg_addr_q  <= addr_q;
              reg_wdata_q <= data_q;
              reg_we_q    <= (cmd_q == CMD_WRITE);
              reg_re_q    <= (cmd_q == CMD_READ);
              state_q     <= S_EXEC;
            end
          end else if (timed_out) begin
            timer_q     <= '0;
            err_count_q <= err_inc;
            busy_q      <= 1'b0;
            state_q     <= S_SYNC;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_EXEC: begin
          nak_q      <= 1'b0;
          resp_idx_q <= 2'd0;
          if (cmd_q == CMD_WRITE) begin
            resp_last_q <= 2'd1;
            state_q     <= S_TXLOAD;
          end else begin
            state_q <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          rdata_q     <= reg_rdata;
          resp_last_q <= 2'd3;
          state_q     <= S_TXLOAD;
        end
        S_TXLOAD: begin
          if (!tx_active) begin
            tx_data_q <= tx_byte;
            tx_send_q <= 1'b1;
            state_q   <= S_TXWAIT;
          end
        end
        S_TXWAIT: begin
          if (tx_done) begin
            if (resp_idx_q == resp_last_q) begin
              busy_q  <= 1'b0;
              state_q <= S_SYNC;
            end else begin
              resp_idx_q <= resp_idx_q + 2'd1;
              state_q    <= S_TXLOAD;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_SYNC;
        end
      endcase
    end
  end

  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign err_count = err_count_q;

endmodule
